hazard_scoreboard: RTL and testbench

- Parametrised successor to the pipeline's single-cycle load-use stall logic.
- Tracks pending register writes from loads, with configurable load latency, and from the single multi-cycle mult/div unit.
- Drives the F/D stall. Issues the multdiv start pulse. Keeps a stall-cycle performance counter.
- Sits beside the F/D and D/X latches; sees each instruction at the moment it would issue from F/D into D/X.

---
 rtl/hazard_scoreboard_pkg.sv | 11 +
 rtl/hazard_scoreboard_reg_busy_counter.sv | 27 ++
 rtl/hazard_scoreboard.sv | 101 ++++++++++
 tb/tb_hazard_scoreboard.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings and defaults for the hazard scoreboard and its per-register counters.
package hazard_defs;

    localparam logic [1:0] CLS_ALU    = 2'b00;
    localparam logic [1:0] CLS_LOAD   = 2'b01;
    localparam logic [1:0] CLS_MULDIV = 2'b10;

    localparam int LOAD_LAT_DEF = 1;
    localparam int CNT_W        = 3;

endpackage

// File: rtl/hazard_scoreboard_reg_busy_counter.sv
// Per-register load-use countdown. A load sets it, and it then counts down to zero.
module reg_busy_counter
    import hazard_defs::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             nonzero
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign nonzero = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// F/D hazard scoreboard: load-use and multdiv RAW/WAW/structural stalls, multdiv start pulse,
// and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_defs::*;
#(
    parameter int REG_W    = 5,
    parameter int NREG     = 32,
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int PERF_W   = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fd_valid,
    input  logic [REG_W-1:0]  fd_rs,
    input  logic [REG_W-1:0]  fd_rt,
    input  logic              fd_use_rs,
    input  logic              fd_use_rt,
    input  logic              fd_wr_en,
    input  logic [REG_W-1:0]  fd_rd,
    input  logic [1:0]        fd_class,
    input  logic              flush,
    input  logic              md_done,
    output logic              stall,
    output logic              md_start,
    output logic              md_busy,
    output logic [NREG-1:0]   busy_mask,
    output logic [PERF_W-1:0] stall_cycles
);

    logic             md_pend;
    logic [REG_W-1:0] md_rd;
    logic             md_live;
    logic             is_load;
    logic             is_md;
    logic             issue;
    logic             md_issue;
    logic [CNT_W-1:0] ld_value;
    logic [NREG-1:0]  ld_busy;
    logic [NREG-1:0]  busy_vec;

    assign is_load  = (fd_class == CLS_LOAD);
    assign is_md    = (fd_class == CLS_MULDIV);
    // A same-cycle md_done releases dependents immediately.
    assign md_live  = md_pend && !md_done;
    assign ld_value = is_load ? CNT_W'(LOAD_LAT) : '0;

    assign ld_busy[0] = 1'b0;
    for (genvar r = 1; r < NREG; r++) begin : g_reg
        reg_busy_counter u_cnt (
            .clock   (clock),
            .reset   (reset),
            .load    (issue && fd_wr_en && (fd_rd == REG_W'(r))),
            .value   (ld_value),
            .nonzero (ld_busy[r])
        );
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_vec[r] = ld_busy[r] || (md_live && (md_rd == REG_W'(r)));
        end
    end

    always_comb begin
        stall = 1'b0;
        if (!reset && fd_valid && !flush) begin
            stall = (fd_use_rs && busy_vec[fd_rs])
                 || (fd_use_rt && busy_vec[fd_rt])
                 || (is_md && md_live)
                 || (fd_wr_en && (fd_rd != '0) && md_live && (md_rd == fd_rd));
        end
    end

    assign issue     = fd_valid && !flush && !stall;
    assign md_issue  = issue && is_md;
    assign busy_mask = reset ? '0 : busy_vec;
    assign md_busy   = md_pend;

    always_ff @(posedge clock) begin
        if (reset) begin
            md_pend      <= 1'b0;
            md_rd        <= '0;
            md_start     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            md_start <= md_issue;
            // A new issue outranks a same-cycle completion.
            if (md_issue) begin
                md_pend <= 1'b1;
                md_rd   <= fd_rd;
            end else if (md_done) begin
                md_pend <= 1'b0;
            end
            if (stall && !(&stall_cycles)) begin
                stall_cycles <= stall_cycles + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard at LOAD_LAT=1, LOAD_LAT=3 and a 2-bit perf counter.
module tb_hazard_scoreboard;
    import hazard_defs::*;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urs;
        logic        urt;
        logic        wr;
        logic [4:0]  rd;
        logic [1:0]  cls;
        logic        fl;
        logic        md;
        logic        e_stall;
        logic        e_start;
        logic        e_busy;
        logic [31:0] e_mask;
        logic [31:0] e_cnt;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        fd_valid, fd_use_rs, fd_use_rt, fd_wr_en, flush, md_done;
    logic [4:0]  fd_rs, fd_rt, fd_rd;
    logic [1:0]  fd_class;

    logic        s1_stall, s1_start, s1_busy;
    logic [31:0] s1_mask, s1_cnt;
    logic        s3_stall, s3_start, s3_busy;
    logic [31:0] s3_mask, s3_cnt;
    logic        ss_stall, ss_start, ss_busy;
    logic [31:0] ss_mask;
    logic [1:0]  ss_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    hazard_scoreboard #(.LOAD_LAT(1)) d1 (
        .clock(clock), .reset(reset), .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_use_rs(fd_use_rs), .fd_use_rt(fd_use_rt), .fd_wr_en(fd_wr_en), .fd_rd(fd_rd),
        .fd_class(fd_class), .flush(flush), .md_done(md_done), .stall(s1_stall),
        .md_start(s1_start), .md_busy(s1_busy), .busy_mask(s1_mask), .stall_cycles(s1_cnt)
    );

    hazard_scoreboard #(.LOAD_LAT(3)) d3 (
        .clock(clock), .reset(reset), .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_use_rs(fd_use_rs), .fd_use_rt(fd_use_rt), .fd_wr_en(fd_wr_en), .fd_rd(fd_rd),
        .fd_class(fd_class), .flush(flush), .md_done(md_done), .stall(s3_stall),
        .md_start(s3_start), .md_busy(s3_busy), .busy_mask(s3_mask), .stall_cycles(s3_cnt)
    );

    hazard_scoreboard #(.LOAD_LAT(1), .PERF_W(2)) ds (
        .clock(clock), .reset(reset), .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_use_rs(fd_use_rs), .fd_use_rt(fd_use_rt), .fd_wr_en(fd_wr_en), .fd_rd(fd_rd),
        .fd_class(fd_class), .flush(flush), .md_done(md_done), .stall(ss_stall),
        .md_start(ss_start), .md_busy(ss_busy), .busy_mask(ss_mask), .stall_cycles(ss_cnt)
    );

    function automatic vec_t mk(
        input logic rst, input logic valid, input logic [4:0] rs, input logic [4:0] rt,
        input logic urs, input logic urt, input logic wr, input logic [4:0] rd,
        input logic [1:0] cls, input logic fl, input logic md,
        input logic e_stall, input logic e_start, input logic e_busy,
        input logic [31:0] e_mask, input logic [31:0] e_cnt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.wr = wr; v.rd = rd; v.cls = cls; v.fl = fl; v.md = md;
        v.e_stall = e_stall; v.e_start = e_start; v.e_busy = e_busy;
        v.e_mask = e_mask; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got 0x%0h, want 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; fd_valid = v.valid; fd_rs = v.rs; fd_rt = v.rt;
        fd_use_rs = v.urs; fd_use_rt = v.urt; fd_wr_en = v.wr; fd_rd = v.rd;
        fd_class = v.cls; flush = v.fl; md_done = v.md;
    endtask

    // Applies one cycle of stimulus and checks the chosen instance before the next edge.
    task automatic apply(input vec_t v, input int idx, input bit lat3);
        logic [31:0] sat;
        @(negedge clock);
        drive(v);
        #1;
        if (!lat3) begin
            check("lat1_stall", idx, {31'b0, s1_stall}, {31'b0, v.e_stall});
            check("lat1_md_start", idx, {31'b0, s1_start}, {31'b0, v.e_start});
            check("lat1_md_busy", idx, {31'b0, s1_busy}, {31'b0, v.e_busy});
            check("lat1_busy_mask", idx, s1_mask, v.e_mask);
            check("lat1_stall_cycles", idx, s1_cnt, v.e_cnt);
            sat = (v.e_cnt > 32'd3) ? 32'd3 : v.e_cnt;
            check("sat_stall_cycles", idx, {30'b0, ss_cnt}, sat);
        end else begin
            check("lat3_stall", idx, {31'b0, s3_stall}, {31'b0, v.e_stall});
            check("lat3_md_start", idx, {31'b0, s3_start}, {31'b0, v.e_start});
            check("lat3_md_busy", idx, {31'b0, s3_busy}, {31'b0, v.e_busy});
            check("lat3_busy_mask", idx, s3_mask, v.e_mask);
            check("lat3_stall_cycles", idx, s3_cnt, v.e_cnt);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        drive(mk(1,0,0,0,0,0,0,0,CLS_ALU,0,0, 0,0,0,0,0));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    vec_t tab1 [27];
    vec_t tab3 [14];

    initial begin
        // LOAD_LAT=1 walk: load-use, multdiv RAW/WAW/structural, r0, flush, reset mid-op.
        tab1[0]  = mk(0,0,0,0,0,0,0,0, CLS_ALU,   0,0, 0,0,0,32'h0,  0);
        tab1[1]  = mk(0,1,1,0,1,0,1,5, CLS_LOAD,  0,0, 0,0,0,32'h0,  0);
        tab1[2]  = mk(0,1,5,2,1,1,1,6, CLS_ALU,   0,0, 1,0,0,32'h20, 0);
        tab1[3]  = mk(0,1,5,2,1,1,1,6, CLS_ALU,   0,0, 0,0,0,32'h0,  1);
        tab1[4]  = mk(0,1,3,4,1,1,1,7, CLS_MULDIV,0,0, 0,0,0,32'h0,  1);
        tab1[5]  = mk(0,1,7,1,1,1,1,8, CLS_ALU,   0,0, 1,1,1,32'h80, 1);
        tab1[6]  = mk(0,1,7,1,1,1,1,8, CLS_ALU,   0,0, 1,0,1,32'h80, 2);
        tab1[7]  = mk(0,1,7,1,1,1,1,8, CLS_ALU,   0,1, 0,0,1,32'h0,  3);
        tab1[8]  = mk(0,0,0,0,0,0,0,0, CLS_ALU,   0,0, 0,0,0,32'h0,  3);
        tab1[9]  = mk(0,1,3,4,1,1,1,7, CLS_MULDIV,0,0, 0,0,0,32'h0,  3);
        tab1[10] = mk(0,1,1,2,1,1,1,10,CLS_MULDIV,0,0, 1,1,1,32'h80, 3);
        tab1[11] = mk(0,1,1,2,1,1,1,7, CLS_ALU,   0,0, 1,0,1,32'h80, 4);
        tab1[12] = mk(0,1,1,2,1,1,1,9, CLS_ALU,   0,0, 0,0,1,32'h80, 5);
        tab1[13] = mk(0,1,1,2,1,1,1,11,CLS_MULDIV,0,1, 0,0,1,32'h0,  5);
        tab1[14] = mk(0,0,0,0,0,0,0,0, CLS_ALU,   0,0, 0,1,1,32'h800,5);
        tab1[15] = mk(0,0,0,0,0,0,0,0, CLS_ALU,   0,1, 0,0,1,32'h0,  5);
        tab1[16] = mk(0,1,1,0,1,0,1,0, CLS_LOAD,  0,1, 0,0,0,32'h0,  5);
        tab1[17] = mk(0,1,0,0,1,1,1,0, CLS_ALU,   0,0, 0,0,0,32'h0,  5);
        tab1[18] = mk(0,1,1,0,1,0,1,5, CLS_LOAD,  0,0, 0,0,0,32'h0,  5);
        tab1[19] = mk(0,1,5,2,1,1,1,6, CLS_ALU,   1,0, 0,0,0,32'h20, 5);
        tab1[20] = mk(0,1,1,2,1,1,1,12,CLS_MULDIV,1,0, 0,0,0,32'h0,  5);
        tab1[21] = mk(0,0,0,0,0,0,0,0, CLS_ALU,   0,0, 0,0,0,32'h0,  5);
        tab1[22] = mk(0,1,3,4,1,1,1,7, CLS_MULDIV,0,0, 0,0,0,32'h0,  5);
        tab1[23] = mk(0,1,1,0,1,0,1,5, CLS_LOAD,  0,0, 0,1,1,32'h80, 5);
        tab1[24] = mk(1,1,7,1,1,1,1,8, CLS_ALU,   0,0, 0,0,1,32'h0,  5);
        tab1[25] = mk(0,0,0,0,0,0,0,0, CLS_ALU,   0,1, 0,0,0,32'h0,  0);
        tab1[26] = mk(0,1,7,5,1,1,1,8, CLS_ALU,   0,0, 0,0,0,32'h0,  0);

        // LOAD_LAT=3: store-data read of r5 never stalls; back-to-back consumer stalls 3 cycles;
        // then reset while multdiv is pending and ld_cnt[5]=2.
        tab3[0]  = mk(0,1,1,0,1,0,1,5, CLS_LOAD,  0,0, 0,0,0,32'h0,  0);
        tab3[1]  = mk(0,1,2,5,1,0,0,0, CLS_ALU,   0,0, 0,0,0,32'h20, 0);
        tab3[2]  = mk(0,1,1,0,1,0,1,5, CLS_LOAD,  0,0, 0,0,0,32'h20, 0);
        tab3[3]  = mk(0,1,5,2,1,1,1,6, CLS_ALU,   0,0, 1,0,0,32'h20, 0);
        tab3[4]  = mk(0,1,5,2,1,1,1,6, CLS_ALU,   0,0, 1,0,0,32'h20, 1);
        tab3[5]  = mk(0,1,5,2,1,1,1,6, CLS_ALU,   0,0, 1,0,0,32'h20, 2);
        tab3[6]  = mk(0,1,5,2,1,1,1,6, CLS_ALU,   0,0, 0,0,0,32'h0,  3);
        tab3[7]  = mk(0,0,0,0,0,0,0,0, CLS_ALU,   0,0, 0,0,0,32'h0,  3);
        tab3[8]  = mk(0,1,3,4,1,1,1,7, CLS_MULDIV,0,0, 0,0,0,32'h0,  3);
        tab3[9]  = mk(0,1,1,0,1,0,1,5, CLS_LOAD,  0,0, 0,1,1,32'h80, 3);
        tab3[10] = mk(0,0,0,0,0,0,0,0, CLS_ALU,   0,0, 0,0,1,32'hA0, 3);
        tab3[11] = mk(1,1,5,7,1,1,1,8, CLS_ALU,   0,0, 0,0,1,32'h0,  3);
        tab3[12] = mk(0,0,0,0,0,0,0,0, CLS_ALU,   0,1, 0,0,0,32'h0,  0);
        tab3[13] = mk(0,0,0,0,0,0,0,0, CLS_ALU,   0,0, 0,0,0,32'h0,  0);

        do_reset();
        for (int i = 0; i < 27; i++) apply(tab1[i], i, 1'b0);

        do_reset();
        for (int i = 0; i < 14; i++) apply(tab3[i], 100 + i, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running, want finished");
        $fatal(1);
    end

endmodule
